// File: rtl/multiword_add_ctrl.sv
// Multi-word adder: streams LS-word-first operand pairs through one ripple-carry adder.
// Latency: 1 cycle accept -> out_valid. Backpressure: single output register; in_ready only when it drains.
// Carry between words lives in a register, so no combinational path spans words.

module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[WIDTH];
endmodule

module multiword_add_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_last,
    output logic             out_cout,
    output logic             busy,
    output logic [CNT_W-1:0] word_count
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    logic             carry_q;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             accept;
    logic             xfer;

    ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (in_a),
        .b    (in_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // in_ready depends only on state and the output handshake, never on in_valid
    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            carry_q    <= 1'b0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_last   <= 1'b0;
            out_cout   <= 1'b0;
            word_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        carry_q    <= cin;
                        word_count <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        out_sum    <= add_sum;
                        out_last   <= in_last;
                        out_valid  <= 1'b1;
                        carry_q    <= add_cout;
                        word_count <= word_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (in_last) begin
                            out_cout <= add_cout;
                            state    <= DRAIN;
                        end
                    end else if (xfer) begin
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed table vectors, hand sequences for backpressure/reset/ignore cases, and a random sweep
// checked against a plain integer-add model of the concatenated operands.
module tb_multiword_add_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cin = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_sum;
    logic       out_last;
    logic       out_cout;
    logic       busy;
    logic [7:0] word_count;

    int n_cmp = 0;
    int n_bad = 0;

    multiword_add_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cin        (cin),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_last   (out_last),
        .out_cout   (out_cout),
        .busy       (busy),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [63:0] exp;
        int          vpct;
        int          rpct;
        bit          glitch;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Runs one operation starting at a negedge while IDLE; returns {cout, sum words}.
    task automatic run_op(input string nm, input int n, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input int vpct, input int rpct, input bit glitch,
                          output logic [63:0] got);
        int   ii;
        int   oi;
        int   cyc;
        bit   gl_done;
        logic acc;
        logic xf;
        ii = 0; oi = 0; cyc = 0; gl_done = 0;
        got = '0;
        start = 1'b1;
        cin   = c;
        @(negedge clk);
        start = 1'b0;
        while (oi < n && cyc < 400) begin
            in_valid = (ii < n) && ($urandom_range(99, 0) < vpct);
            if (ii < n) begin
                in_a = a[4*ii +: 4];
                in_b = b[4*ii +: 4];
            end
            in_last   = (ii == n - 1);
            out_ready = ($urandom_range(99, 0) < rpct);
            if (glitch && !gl_done && ii == 1) begin
                start   = 1'b1;
                cin     = ~c;
                gl_done = 1;
            end
            #1;
            acc = in_valid && in_ready;
            xf  = out_valid && out_ready;
            if (xf) begin
                got[4*oi +: 4] = out_sum;
                check({nm, " out_last"}, 64'(out_last), 64'(oi == n - 1));
                if (oi == n - 1) got[4*n] = out_cout;
                oi++;
            end
            if (acc) ii++;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (oi < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got %0d words required %0d", nm, oi, n);
        end
        check({nm, " busy"}, 64'(busy), 64'(0));
        check({nm, " word_count"}, 64'(word_count), 64'(n));
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] mask;
        logic [63:0] exp;
        int          n;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;

        vecs[0] = '{2, 32'h0F,       32'h01,       1'b0, 64'h010,        100, 100, 1'b0};
        vecs[1] = '{1, 32'hF,        32'hF,        1'b1, 64'h1F,         100, 100, 1'b0};
        vecs[2] = '{4, 32'h1234,     32'h4321,     1'b0, 64'h5555,       60,  70,  1'b0};
        vecs[3] = '{4, 32'hFFFF,     32'h0000,     1'b1, 64'h10000,      100, 50,  1'b1};
        vecs[4] = '{8, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h1FFFFFFFF,  80,  80,  1'b0};
        vecs[5] = '{3, 32'hABC,      32'h123,      1'b0, 64'hBDF,        100, 100, 1'b1};
        vecs[6] = '{2, 32'h80,       32'h80,       1'b0, 64'h100,        50,  100, 1'b0};

        repeat (3) @(negedge clk);
        check("rst in_ready",   64'(in_ready),   64'(0));
        check("rst busy",       64'(busy),       64'(0));
        check("rst out_valid",  64'(out_valid),  64'(0));
        check("rst out_sum",    64'(out_sum),    64'(0));
        check("rst out_last",   64'(out_last),   64'(0));
        check("rst out_cout",   64'(out_cout),   64'(0));
        check("rst word_count", 64'(word_count), 64'(0));
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_op($sformatf("vec%0d", v), vecs[v].n, vecs[v].a, vecs[v].b, vecs[v].c,
                   vecs[v].vpct, vecs[v].rpct, vecs[v].glitch, got);
            check($sformatf("vec%0d result", v), got, vecs[v].exp);
        end

        // in_valid while IDLE must not be accepted and must not touch word_count
        in_valid = 1'b1; in_a = 4'h1; in_b = 4'h1; in_last = 1'b1; out_ready = 1'b1;
        repeat (3) begin
            #1;
            check("idle in_ready", 64'(in_ready), 64'(0));
            @(negedge clk);
        end
        check("idle busy",       64'(busy),       64'(0));
        check("idle out_valid",  64'(out_valid),  64'(0));
        check("idle word_count", 64'(word_count), 64'(vecs[6].n));
        in_valid = 1'b0; out_ready = 1'b0;

        // Backpressure: 0x5A + 0x3C = 0x96, first word held for 3 stalled cycles
        start = 1'b1; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_a = 4'hA; in_b = 4'hC; in_last = 1'b0; out_ready = 1'b0;
        #1;
        check("bp first in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        in_a = 4'h5; in_b = 4'h3; in_last = 1'b1;
        repeat (3) begin
            #1;
            check("bp stall in_ready",  64'(in_ready),  64'(0));
            check("bp stall out_valid", 64'(out_valid), 64'(1));
            check("bp stall out_sum",   64'(out_sum),   64'(4'h6));
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp resume in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("bp word1 out_sum",  64'(out_sum),  64'(4'h9));
        check("bp word1 out_last", 64'(out_last), 64'(1));
        check("bp word1 out_cout", 64'(out_cout), 64'(0));
        check("bp word1 valid",    64'(out_valid), 64'(1));
        @(negedge clk);
        out_ready = 1'b0;
        check("bp done busy",       64'(busy),       64'(0));
        check("bp done word_count", 64'(word_count), 64'(2));

        // Reset in RUN after one of three words
        start = 1'b1; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_a = 4'h3; in_b = 4'h4; in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid word_count", 64'(word_count), 64'(1));
        check("mid busy",       64'(busy),       64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid rst busy",       64'(busy),       64'(0));
        check("mid rst out_valid",  64'(out_valid),  64'(0));
        check("mid rst word_count", 64'(word_count), 64'(0));
        check("mid rst out_sum",    64'(out_sum),    64'(0));
        run_op("post rst", vecs[2].n, vecs[2].a, vecs[2].b, vecs[2].c, 100, 100, 1'b0, got);
        check("post rst result", got, vecs[2].exp);

        for (int k = 0; k < 1000; k++) begin
            n    = int'($urandom_range(8, 1));
            a    = $urandom;
            b    = $urandom;
            c    = 1'($urandom_range(1, 0));
            mask = (64'd1 << (4 * n)) - 64'd1;
            exp  = (64'(a) & mask) + (64'(b) & mask) + 64'(c);
            run_op($sformatf("rand%0d", k), n, a, b, c, int'($urandom_range(100, 30)),
                   int'($urandom_range(100, 30)), 1'b0, got);
            check($sformatf("rand%0d result", k), got, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
